// File: rtl/qproc_ctrl_fsm_if.sv
// Command/status bundle between the tProcessor AXI register block and the run-control FSM.
// The master side drives commands and configuration; the slave side returns control and status.
interface qproc_ctrl_fsm_if;
    logic [31:0] tproc_ctrl_i;
    logic [31:0] tproc_cfg_i;
    logic        ext_start_i;
    logic        core_halt_i;
    logic        core_rst_o;
    logic        core_en_o;
    logic        time_rst_o;
    logic        time_en_o;
    logic        time_updt_o;
    logic [2:0]  state_o;
    logic [15:0] step_cnt_o;
    logic        cmd_err_o;

    modport master (
        output tproc_ctrl_i, tproc_cfg_i, ext_start_i, core_halt_i,
        input  core_rst_o, core_en_o, time_rst_o, time_en_o, time_updt_o,
        input  state_o, step_cnt_o, cmd_err_o
    );

    modport slave (
        input  tproc_ctrl_i, tproc_cfg_i, ext_start_i, core_halt_i,
        output core_rst_o, core_en_o, time_rst_o, time_en_o, time_updt_o,
        output state_o, step_cnt_o, cmd_err_o
    );
endinterface

// File: rtl/qproc_ctrl_fsm.sv
// tProcessor run-control state machine: turns TPROC_CTRL command pulses into core and
// time-base reset/enable controls. All outputs are registered, decoded from the next state.
module qproc_ctrl_fsm #(
    parameter int unsigned RST_CYC = 4
) (
    input logic             c_clk_i,
    input logic             c_rst_ni,
    qproc_ctrl_fsm_if.slave bus
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_STOP   = 3'd1,
        ST_RUN    = 3'd2,
        ST_PAUSE  = 3'd3,
        ST_FREEZE = 3'd4,
        ST_STEP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_RUN,
        CMD_STEP,
        CMD_PAUSE,
        CMD_FREEZE,
        CMD_STOP,
        CMD_RST
    } cmd_e;

    localparam logic [7:0] RST_LOAD = 8'(RST_CYC - 1);

    state_e      state_q, state_d;
    state_e      origin_q, origin_d;
    cmd_e        pend_q, pend_d;
    cmd_e        cmd_in, cmd_eff;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] step_cnt_q, step_cnt_d;
    logic        err_q, err_d;
    logic        err_set, rst_entry, run_req;
    logic        core_rst_q, core_rst_d;
    logic        core_en_q, core_en_d;
    logic        time_rst_q, time_rst_d;
    logic        time_en_q, time_en_d;
    logic        time_updt_q, time_updt_d;

    logic unused_bits;
    assign unused_bits = ^{bus.tproc_ctrl_i[31:8], bus.tproc_cfg_i[31:1]};

    always_comb begin
        // NOTE: every signal written here is defaulted first, so no path can infer a latch.
        cmd_in    = CMD_NONE;
        state_d   = state_q;
        origin_d  = origin_q;
        cnt_d     = cnt_q;
        pend_d    = CMD_NONE;
        err_set   = 1'b0;
        rst_entry = 1'b0;
        run_req   = bus.tproc_ctrl_i[2] | (bus.ext_start_i & bus.tproc_cfg_i[0]);

        if (bus.tproc_ctrl_i[7])      cmd_in = CMD_RST;
        else if (bus.tproc_ctrl_i[3]) cmd_in = CMD_STOP;
        else if (bus.tproc_ctrl_i[5]) cmd_in = CMD_FREEZE;
        else if (bus.tproc_ctrl_i[4]) cmd_in = CMD_PAUSE;
        else if (bus.tproc_ctrl_i[6]) cmd_in = CMD_STEP;
        else if (run_req)             cmd_in = CMD_RUN;

        // A command parked during STEP is replayed unless a fresh one supersedes it.
        cmd_eff = (cmd_in != CMD_NONE) ? cmd_in : pend_q;

        if (state_q != ST_STEP && cmd_eff == CMD_RST) begin
            state_d   = ST_RESET;
            cnt_d     = RST_LOAD;
            rst_entry = 1'b1;
        end else begin
            case (state_q)
                ST_RESET: begin
                    err_set = (cmd_eff != CMD_NONE);
                    if (cnt_q == 8'd0) state_d = ST_STOP;
                    else               cnt_d   = cnt_q - 8'd1;
                end
                ST_STOP: begin
                    case (cmd_eff)
                        CMD_RUN:                        state_d = ST_RUN;
                        CMD_PAUSE, CMD_FREEZE, CMD_STEP: err_set = 1'b1;
                        default: ;
                    endcase
                end
                ST_RUN: begin
                    if (bus.core_halt_i) begin
                        state_d = ST_STOP;
                    end else begin
                        case (cmd_eff)
                            CMD_STOP:   state_d = ST_STOP;
                            CMD_PAUSE:  state_d = ST_PAUSE;
                            CMD_FREEZE: state_d = ST_FREEZE;
                            CMD_STEP:   err_set = 1'b1;
                            default: ;
                        endcase
                    end
                end
                ST_PAUSE, ST_FREEZE: begin
                    case (cmd_eff)
                        CMD_RUN:    state_d = ST_RUN;
                        CMD_STOP:   state_d = ST_STOP;
                        CMD_PAUSE:  state_d = ST_PAUSE;
                        CMD_FREEZE: state_d = ST_FREEZE;
                        CMD_STEP: begin
                            state_d  = ST_STEP;
                            origin_d = state_q;
                        end
                        default: ;
                    endcase
                end
                ST_STEP: begin
                    // A halt during the step wins; any pending command then applies from STOP.
                    state_d = bus.core_halt_i ? ST_STOP : origin_q;
                    pend_d  = cmd_in;
                end
                default: begin
                    state_d = ST_RESET;
                    cnt_d   = RST_LOAD;
                end
            endcase
        end

        step_cnt_d = step_cnt_q;
        if (rst_entry)
            step_cnt_d = 16'd0;
        else if (state_d == ST_STEP && step_cnt_q != 16'hFFFF)
            step_cnt_d = step_cnt_q + 16'd1;

        err_d = rst_entry ? 1'b0 : (err_q | err_set);

        core_rst_d  = (state_d == ST_RESET);
        core_en_d   = (state_d == ST_RUN) || (state_d == ST_STEP);
        time_en_d   = (state_d == ST_RUN) || (state_d == ST_PAUSE) || (state_d == ST_STEP);
        time_rst_d  = bus.tproc_ctrl_i[0] | (state_d == ST_RESET);
        time_updt_d = bus.tproc_ctrl_i[1];
    end

    always_ff @(posedge c_clk_i) begin
        // NOTE: non-blocking assignments so every register samples the same pre-edge values.
        if (!c_rst_ni) begin
            state_q     <= ST_RESET;
            origin_q    <= ST_PAUSE;
            pend_q      <= CMD_NONE;
            cnt_q       <= RST_LOAD;
            step_cnt_q  <= 16'd0;
            err_q       <= 1'b0;
            core_rst_q  <= 1'b1;
            core_en_q   <= 1'b0;
            time_rst_q  <= 1'b1;
            time_en_q   <= 1'b0;
            time_updt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            origin_q    <= origin_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            step_cnt_q  <= step_cnt_d;
            err_q       <= err_d;
            core_rst_q  <= core_rst_d;
            core_en_q   <= core_en_d;
            time_rst_q  <= time_rst_d;
            time_en_q   <= time_en_d;
            time_updt_q <= time_updt_d;
        end
    end

    assign bus.state_o     = state_q;
    assign bus.step_cnt_o  = step_cnt_q;
    assign bus.cmd_err_o   = err_q;
    assign bus.core_rst_o  = core_rst_q;
    assign bus.core_en_o   = core_en_q;
    assign bus.time_rst_o  = time_rst_q;
    assign bus.time_en_o   = time_en_q;
    assign bus.time_updt_o = time_updt_q;

endmodule

// File: tb/tb_qproc_ctrl_fsm.sv
// Self-checking bench for qproc_ctrl_fsm: directed scenarios followed by random command traffic,
// each cycle compared against a behavioural model of the run-control rules.
module tb_qproc_ctrl_fsm;

    localparam int RST_CYC = 4;

    localparam logic [31:0] C_TRST   = 32'h01;
    localparam logic [31:0] C_TUPDT  = 32'h02;
    localparam logic [31:0] C_RUN    = 32'h04;
    localparam logic [31:0] C_STOP   = 32'h08;
    localparam logic [31:0] C_PAUSE  = 32'h10;
    localparam logic [31:0] C_FREEZE = 32'h20;
    localparam logic [31:0] C_STEP   = 32'h40;
    localparam logic [31:0] C_RST    = 32'h80;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cfg = 32'h0;

    qproc_ctrl_fsm_if bus ();

    qproc_ctrl_fsm #(.RST_CYC(RST_CYC)) dut (
        .c_clk_i (clk),
        .c_rst_ni(rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: state codes follow the published encoding; commands are their TPROC_CTRL bit index.
    int m_state, m_cnt, m_step, m_err, m_pend, m_orig, m_trst, m_tupdt;

    function automatic int pick(input logic [31:0] ctrl, input bit run);
        int         prio [6];
        logic [7:0] v;
        prio = '{7, 3, 5, 4, 6, 2};
        v    = ctrl[7:0];
        v[2] = v[2] | run;
        for (int i = 0; i < 6; i++)
            if (v[prio[i]]) return prio[i];
        return -1;
    endfunction

    function automatic int target(input int c);
        case (c)
            2:       return 2;
            3:       return 1;
            4:       return 3;
            5:       return 4;
            6:       return 5;
            default: return -1;
        endcase
    endfunction

    function automatic bit legal(input int st, input int c);
        case (st)
            1:       return c == 2;
            2:       return c == 3 || c == 4 || c == 5;
            3, 4:    return c >= 2 && c <= 6;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit silent(input int st, input int c);
        return (st == 1 && c == 3) || (st == 2 && c == 2);
    endfunction

    task automatic model_step(input logic [31:0] ctrl, input bit ext, input bit halt, input bit rn);
        int c;
        int nxt;
        bit entry;
        bit bad;
        if (!rn) begin
            m_state = 0; m_cnt = RST_CYC - 1; m_step = 0; m_err = 0;
            m_pend = -1; m_orig = 3; m_trst = 1; m_tupdt = 0;
            return;
        end
        c     = pick(ctrl, ext & cfg[0]);
        nxt   = m_state;
        entry = 1'b0;
        bad   = 1'b0;
        if (m_state == 5) begin
            nxt    = halt ? 1 : m_orig;
            m_pend = c;
        end else begin
            if (c < 0) c = m_pend;
            m_pend = -1;
            if (c == 7) begin
                nxt = 0; m_cnt = RST_CYC - 1; entry = 1'b1;
            end else if (m_state == 0) begin
                bad = (c >= 0);
                if (m_cnt == 0) nxt = 1;
                else            m_cnt = m_cnt - 1;
            end else if (m_state == 2 && halt) begin
                nxt = 1;
            end else if (c >= 0) begin
                if (legal(m_state, c)) begin
                    nxt = target(c);
                    if (c == 6) m_orig = m_state;
                end else begin
                    bad = !silent(m_state, c);
                end
            end
        end
        if (entry) begin
            m_step = 0; m_err = 0;
        end else begin
            if (nxt == 5 && m_step < 65535) m_step = m_step + 1;
            if (bad) m_err = 1;
        end
        m_state = nxt;
        m_trst  = (ctrl[0] || nxt == 0) ? 1 : 0;
        m_tupdt = ctrl[1] ? 1 : 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare(input string tag);
        chk({tag, ".state"},     32'(bus.state_o),     32'(m_state));
        chk({tag, ".core_rst"},  32'(bus.core_rst_o),  32'(m_state == 0));
        chk({tag, ".core_en"},   32'(bus.core_en_o),   32'(m_state == 2 || m_state == 5));
        chk({tag, ".time_en"},   32'(bus.time_en_o),   32'(m_state == 2 || m_state == 3 || m_state == 5));
        chk({tag, ".time_rst"},  32'(bus.time_rst_o),  32'(m_trst));
        chk({tag, ".time_updt"}, 32'(bus.time_updt_o), 32'(m_tupdt));
        chk({tag, ".step_cnt"},  32'(bus.step_cnt_o),  32'(m_step));
        chk({tag, ".cmd_err"},   32'(bus.cmd_err_o),   32'(m_err));
    endtask

    task automatic cycle(input string tag, input logic [31:0] ctrl, input bit ext, input bit halt);
        bus.tproc_ctrl_i = ctrl;
        bus.tproc_cfg_i  = cfg;
        bus.ext_start_i  = ext;
        bus.core_halt_i  = halt;
        model_step(ctrl, ext, halt, rst_n);
        @(posedge clk);
        #1;
        compare(tag);
        bus.tproc_ctrl_i = '0;
        bus.ext_start_i  = 1'b0;
        bus.core_halt_i  = 1'b0;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, '0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] ctrl;

        bus.tproc_ctrl_i = '0;
        bus.tproc_cfg_i  = '0;
        bus.ext_start_i  = 1'b0;
        bus.core_halt_i  = 1'b0;

        // Reset hold, release, RESET lasts RST_CYC cycles.
        rst_n = 1'b0;
        idle("rst_hold", 3);
        chk("rst_hold.core_rst_const", 32'(bus.core_rst_o), 32'd1);
        rst_n = 1'b1;
        idle("rst_release", RST_CYC - 1);
        chk("rst_release.still_reset", 32'(bus.state_o), 32'd0);
        idle("rst_exit", 1);
        chk("rst_exit.stop_const", 32'(bus.state_o), 32'd1);

        // RUN, then halt ten cycles later.
        cycle("run", C_RUN, 1'b0, 1'b0);
        chk("run.core_en_const", 32'(bus.core_en_o), 32'd1);
        idle("running", 9);
        cycle("halt", C_TUPDT | C_TRST, 1'b0, 1'b1);
        chk("halt.stop_const", 32'(bus.state_o), 32'd1);
        chk("halt.time_updt_const", 32'(bus.time_updt_o), 32'd1);

        // RUN, PAUSE, three spaced steps.
        cycle("run2", C_RUN, 1'b0, 1'b0);
        cycle("pause", C_PAUSE, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle("pstep", C_STEP, 1'b0, 1'b0);
            chk("pstep.core_en_const", 32'(bus.core_en_o), 32'd1);
            idle("pstep_gap", 4);
        end
        chk("pstep.count_const", 32'(bus.step_cnt_o), 32'd3);
        chk("pstep.back_const", 32'(bus.state_o), 32'd3);

        // Priority discard, ignored command error, reset clears.
        cycle("run3", C_RUN, 1'b0, 1'b0);
        cycle("stop_run", C_STOP | C_RUN, 1'b0, 1'b0);
        cycle("step_in_stop", C_STEP, 1'b0, 1'b0);
        chk("step_in_stop.err_const", 32'(bus.cmd_err_o), 32'd1);
        cycle("proc_rst", C_RST, 1'b0, 1'b0);
        chk("proc_rst.err_const", 32'(bus.cmd_err_o), 32'd0);
        idle("proc_rst_wait", RST_CYC);

        // External start gating.
        cfg = 32'h0;
        cycle("ext_off", '0, 1'b1, 1'b0);
        cfg = 32'h1;
        cycle("ext_on", '0, 1'b1, 1'b0);
        chk("ext_on.run_const", 32'(bus.state_o), 32'd2);
        cfg = 32'h0;

        // FREEZE with back-to-back steps, then reset mid-stream.
        cycle("freeze", C_FREEZE, 1'b0, 1'b0);
        cycle("fstep1", C_STEP, 1'b0, 1'b0);
        cycle("fstep2", C_STEP, 1'b0, 1'b0);
        chk("fstep2.gap_const", 32'(bus.core_en_o), 32'd0);
        idle("fstep_pend", 1);
        chk("fstep_pend.en_const", 32'(bus.core_en_o), 32'd1);
        idle("fstep_back", 1);
        chk("fstep_back.freeze_const", 32'(bus.state_o), 32'd4);
        rst_n = 1'b0;
        cycle("mid_rst", C_RUN, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle("mid_rst_wait", RST_CYC);

        // Random command traffic.
        for (int i = 0; i < 3000; i++) begin
            ctrl = {$urandom} & 32'hFFFF_FF00;
            for (int b = 0; b < 8; b++)
                if ($urandom_range((b == 7) ? 59 : 7, 0) == 0) ctrl[b] = 1'b1;
            cfg   = $urandom;
            rst_n = ($urandom_range(299, 0) != 0);
            cycle("rand", ctrl, ($urandom_range(9, 0) == 0), ($urandom_range(11, 0) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
